// File: rtl/fft_pkg.sv
// ============================================================================
// Package  : fft_pkg
// Brief    : Shared complex types and arithmetic helpers for the FFT datapath
// Revision : 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int C_MAXW = 64;

    typedef logic signed [C_MAXW-1:0] wide_t;

    typedef struct packed {
        wide_t re;
        wide_t im;
    } cplx_t;

    typedef struct packed {
        logic  clip;
        wide_t val;
    } sat_t;

    function automatic int half_of(input int width);
        return width / 2;
    endfunction

    // Keep the low 'bits' bits of v and sign-extend them back to full width.
    function automatic wide_t sext(input wide_t v, input int bits);
        wide_t m;
        m = v <<< (C_MAXW - bits);
        return m >>> (C_MAXW - bits);
    endfunction

    function automatic cplx_t cadd(input cplx_t x, input cplx_t y);
        cplx_t r;
        r.re = x.re + y.re;
        r.im = x.im + y.im;
        return r;
    endfunction

    function automatic cplx_t csub(input cplx_t x, input cplx_t y);
        cplx_t r;
        r.re = x.re - y.re;
        r.im = x.im - y.im;
        return r;
    endfunction

    function automatic cplx_t mul_j(input cplx_t x);
        cplx_t r;
        r.re = -x.im;
        r.im = x.re;
        return r;
    endfunction

    // Complex product rounded half-up at 'frac' and wrapped to half+1 bits.
    function automatic cplx_t cmul_round(input cplx_t x, input cplx_t w,
                                         input int frac, input int half);
        cplx_t r;
        wide_t rnd;
        rnd  = wide_t'(1) <<< (frac - 1);
        r.re = sext((x.re * w.re - x.im * w.im + rnd) >>> frac, half + 1);
        r.im = sext((x.im * w.re + x.re * w.im + rnd) >>> frac, half + 1);
        return r;
    endfunction

    function automatic sat_t sat_half(input wide_t v, input int half);
        sat_t  r;
        wide_t hi;
        wide_t lo;
        hi     = (wide_t'(1) <<< (half - 1)) - wide_t'(1);
        lo     = -(wide_t'(1) <<< (half - 1));
        r.clip = 1'b0;
        r.val  = v;
        if (v > hi) begin
            r.val  = hi;
            r.clip = 1'b1;
        end else if (v < lo) begin
            r.val  = lo;
            r.clip = 1'b1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmul_pipe.sv
// ============================================================================
// Module   : cmul_pipe
// Brief    : Registered complex multiply by a twiddle with half-up rounding
// Revision : 1.0
// ============================================================================
`default_nettype none

module cmul_pipe
    import fft_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TW_FRAC = WIDTH / 2 - 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en,
    input  logic [WIDTH-1:0]              i_x,
    input  logic [WIDTH+1:0]              i_w,
    output logic [2*half_of(WIDTH)+1:0]   o_p
);

    localparam int C_HALF = half_of(WIDTH);

    cplx_t                 w_x;
    cplx_t                 w_w;
    cplx_t                 w_p;
    logic [2*C_HALF+1:0]   r_p;
    logic                  w_unused;

    always_comb begin
        w_x.re = wide_t'($signed(i_x[WIDTH-1:C_HALF]));
        w_x.im = wide_t'($signed(i_x[C_HALF-1:0]));
        w_w.re = wide_t'($signed(i_w[WIDTH+1:C_HALF+1]));
        w_w.im = wide_t'($signed(i_w[C_HALF:0]));
        w_p    = cmul_round(w_x, w_w, TW_FRAC, C_HALF);
    end

    // Upper bits are sign copies after the wrap to C_HALF+1 bits.
    assign w_unused = ^{w_p.re[C_MAXW-1:C_HALF+1], w_p.im[C_MAXW-1:C_HALF+1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p <= '0;
        end else if (i_en) begin
            r_p <= {w_p.re[C_HALF:0], w_p.im[C_HALF:0]};
        end
    end

    assign o_p = r_p;

endmodule

`default_nettype wire

// File: rtl/butterfly_4_pipe.sv
// ============================================================================
// Module   : butterfly_4_pipe
// Brief    : Three-stage radix-4 DIT butterfly with global stall, /4 scaling,
//            saturation and sticky overflow
// Revision : 1.0
// ============================================================================
`default_nettype none

module butterfly_4_pipe
    import fft_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TW_FRAC = WIDTH / 2 - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH+1:0] w1,
    input  logic [WIDTH+1:0] w2,
    input  logic [WIDTH+1:0] w3,
    input  logic             inverse,
    input  logic             scale,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int C_HALF = half_of(WIDTH);
    localparam int C_PW   = 2 * C_HALF + 2;

    logic             w_advance;

    logic             r_s1_valid;
    logic             r_s1_inv;
    logic             r_s1_scale;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_x [3];
    logic [WIDTH+1:0] r_s1_w [3];

    logic             r_s2_valid;
    logic             r_s2_inv;
    logic             r_s2_scale;
    logic [WIDTH-1:0] r_s2_a;
    logic [C_PW-1:0]  w_prod [3];

    logic             r_out_valid;
    logic             r_ovf;
    logic [WIDTH-1:0] r_out [4];

    cplx_t            w_a;
    cplx_t            w_t [3];
    cplx_t            w_jt1;
    cplx_t            w_jt3;
    cplx_t            w_fwd1;
    cplx_t            w_fwd3;
    cplx_t            w_sum [4];
    wide_t            w_re [4];
    wide_t            w_im [4];
    sat_t             w_sat_re [4];
    sat_t             w_sat_im [4];
    logic [WIDTH-1:0] w_res [4];
    logic             w_clip;
    logic             w_unused;

    // Single global stall: every stage moves together, bubbles included.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_inv   <= 1'b0;
            r_s1_scale <= 1'b0;
            r_s1_a     <= '0;
            for (int k = 0; k < 3; k++) begin
                r_s1_x[k] <= '0;
                r_s1_w[k] <= '0;
            end
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s1_inv   <= inverse;
            r_s1_scale <= scale;
            r_s1_a     <= a;
            r_s1_x[0]  <= b;
            r_s1_x[1]  <= c;
            r_s1_x[2]  <= d;
            r_s1_w[0]  <= w1;
            r_s1_w[1]  <= w2;
            r_s1_w[2]  <= w3;
        end
    end

    generate
        for (genvar k = 0; k < 3; k++) begin : g_cmul
            cmul_pipe #(
                .WIDTH   (WIDTH),
                .TW_FRAC (TW_FRAC)
            ) u_cmul (
                .clk  (clk),
                .rst  (rst),
                .i_en (w_advance),
                .i_x  (r_s1_x[k]),
                .i_w  (r_s1_w[k]),
                .o_p  (w_prod[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_inv   <= 1'b0;
            r_s2_scale <= 1'b0;
            r_s2_a     <= '0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            r_s2_inv   <= r_s1_inv;
            r_s2_scale <= r_s1_scale;
            r_s2_a     <= r_s1_a;
        end
    end

    always_comb begin
        w_a.re = wide_t'($signed(r_s2_a[WIDTH-1:C_HALF]));
        w_a.im = wide_t'($signed(r_s2_a[C_HALF-1:0]));
        for (int k = 0; k < 3; k++) begin
            w_t[k].re = wide_t'($signed(w_prod[k][C_PW-1:C_HALF+1]));
            w_t[k].im = wide_t'($signed(w_prod[k][C_HALF:0]));
        end
        w_jt1  = mul_j(w_t[0]);
        w_jt3  = mul_j(w_t[2]);
        w_fwd1 = csub(cadd(csub(w_a, w_jt1), w_jt3), w_t[1]);
        w_fwd3 = csub(csub(cadd(w_a, w_jt1), w_t[1]), w_jt3);
        w_sum[0] = cadd(cadd(w_a, w_t[0]), cadd(w_t[1], w_t[2]));
        w_sum[2] = csub(cadd(csub(w_a, w_t[0]), w_t[1]), w_t[2]);
        // Inverse rotates by +j, which only exchanges the odd outputs.
        w_sum[1] = r_s2_inv ? w_fwd3 : w_fwd1;
        w_sum[3] = r_s2_inv ? w_fwd1 : w_fwd3;

        w_clip = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_re[k] = sext(w_sum[k].re, C_HALF + 3);
            w_im[k] = sext(w_sum[k].im, C_HALF + 3);
            if (r_s2_scale) begin
                w_re[k] = (w_re[k] + wide_t'(2)) >>> 2;
                w_im[k] = (w_im[k] + wide_t'(2)) >>> 2;
            end
            w_sat_re[k] = sat_half(w_re[k], C_HALF);
            w_sat_im[k] = sat_half(w_im[k], C_HALF);
            w_res[k]    = {w_sat_re[k].val[C_HALF-1:0], w_sat_im[k].val[C_HALF-1:0]};
            w_clip      = w_clip | w_sat_re[k].clip | w_sat_im[k].clip;
        end
    end

    always_comb begin
        w_unused = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_unused = w_unused ^ (^w_sat_re[k].val[C_MAXW-1:C_HALF])
                                ^ (^w_sat_im[k].val[C_MAXW-1:C_HALF]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_out[k] <= '0;
            end
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            for (int k = 0; k < 4; k++) begin
                r_out[k] <= w_res[k];
            end
        end
    end

    // Set on loading a clipped beat into the output stage; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_advance && r_s2_valid && w_clip) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
    assign out0      = r_out[0];
    assign out1      = r_out[1];
    assign out2      = r_out[2];
    assign out3      = r_out[3];

endmodule

`default_nettype wire

// File: doc/butterfly_4_pipe.md
# butterfly_4_pipe

Pipelined, parametrised radix-4 decimation-in-time butterfly for the FFT datapath of the audio visualiser. It accepts one set of four packed complex samples and three twiddle factors per beat under a valid/ready handshake. It produces four packed complex outputs three cycles later and supports inverse-transform and per-stage /4 scaling modes. Outputs saturate, and overflow is reported on a sticky flag. It replaces the combinational butterfly in the stage sequencer, so the multiply and add paths are no longer one long combinational path.

## Interface
Parameters:
- WIDTH, 32, packed complex sample width; upper WIDTH/2 bits are real, lower WIDTH/2 bits are imaginary, both two's complement (HALF = WIDTH/2).
- TW_FRAC, WIDTH/2-1, fractional bits of each twiddle half; twiddle halves are HALF+1 bits wide, so +1.0 = 1<<TW_FRAC is representable.

Ports (one synchronous clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a, b, c, d  in  WIDTH  packed complex inputs.
- w1, w2, w3  in  WIDTH+2  packed twiddles; real half is [WIDTH+1:HALF+1], imaginary half is [HALF:0].
- inverse  in  1  sampled with the beat; selects +j rotation instead of −j.
- scale  in  1  sampled with the beat; 1 = divide results by 4 with rounding.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts.
- out0, out1, out2, out3  out  WIDTH  packed complex results.
- ovf  out  1  sticky saturation flag.
- ovf_clr  in  1  clears ovf.

## Operation
- Products: t_k = x_k·w_k, with x = b, c, d.
  - Real part of t_k: xr·wr − xi·wi. Imaginary part: xi·wr + xr·wi.
  - Compute in 2·HALF+2 bits.
  - Round half-up: add 1<<(TW_FRAC−1), then arithmetic shift right by TW_FRAC.
  - Keep HALF+1 bits; no saturation at this point.
- Forward mode (inverse = 0):
  - out0 = a + t1 + t2 + t3
  - out1 = a − j·t1 − t2 + j·t3
  - out2 = a − t1 + t2 − t3
  - out3 = a + j·t1 − t2 − j·t3
- Inverse mode (inverse = 1): the expressions for out1 and out3 are swapped. out0 and out2 are unchanged.
- Multiplying by j maps (r, i) to (−i, r).
- Sums are formed in HALF+3 bits.
- If scale = 1: add 2, then arithmetic shift right by 2.
- Each half is then saturated to [−2^(HALF−1), 2^(HALF−1)−1].
- Any clipped half in an accepted output beat sets ovf. ovf stays set until ovf_clr or rst.
- If ovf_clr and a new clip occur in the same cycle, ovf = 1 (set wins).
- inverse and scale travel with their beat; changing them mid-stream affects only the beats sampled afterwards.

## Timing
- Three register stages:
  - S1: input capture.
  - S2: registered twiddle products, after rounding.
  - S3: registered sums after scaling and saturation, driving out*.
- Latency: an input accepted in cycle n appears with out_valid in cycle n+3 when there is no stall.
- Global stall: advance = !out_valid | out_ready.
  - in_ready = advance, combinational.
  - All stages shift only when advance = 1.
  - Bubbles are not collapsed.
- A beat is accepted when in_valid & in_ready; it is delivered when out_valid & out_ready.
- out* and out_valid stay stable while out_valid & !out_ready.
- Throughput: one beat per cycle with out_ready held high.
- The pipeline holds at most 3 beats.
- Reset values:
  - All stage valids = 0, out_valid = 0, ovf = 0, out0–out3 = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation discards every in-flight beat; no partial beat is emitted.

## Structure
- Shared package fft_pkg holds:
  - the HALF derivation;
  - a cplx_t struct (real and imaginary halves);
  - helper functions cmul_round, sat_half and mul_j.
- One sub-module, cmul_pipe: a registered complex multiply with rounding. It is instantiated three times to form S2.
- Adder/saturation logic and the valid/stall control live in butterfly_4_pipe.

## Test plan
All scenarios use WIDTH = 32 and TW_FRAC = 15 (twiddle 1.0 = real 32768, imag 0).

1. All inputs (100, 0), all twiddles 1.0, forward, scale = 0:
   - out0 = (400, 0); out1, out2, out3 = (0, 0).
   - out_valid is asserted exactly 3 cycles after acceptance.
2. Inverse check: a = c = d = 0, b = (100, 0), w1 = 1.0.
   - Forward: out1 = (0, −100), out3 = (0, 100).
   - Inverse: out1 = (0, 100), out3 = (0, −100).
3. Saturation: all inputs (30000, −30000), twiddles 1.0, scale = 0:
   - out0 = (32767, −32768) and ovf = 1.
   - Repeat with scale = 1: out0 = (30000, −30000) with no new clip. Pulse ovf_clr first, then check ovf = 0.
4. Backpressure: stream 6 beats; hold out_ready = 0 from cycle 4 to cycle 9.
   - in_ready drops while out_valid & !out_ready, at most 3 beats are held, and out* is stable.
   - All 6 results emerge in order with no loss or duplication.
5. Rounding: b = (1, 0), w1 = (16384, 0), i.e. 0.5, others 0:
   - t1 = (1, 0), rounded half-up, so out0 = (1, 0).
   - With b = (−1, 0): t1 = (0, 0), so out0 = (0, 0).
6. Reset mid-stream: assert rst for 1 cycle with 2 beats in flight.
   - out_valid = 0, ovf = 0 and in_ready = 1 in the following cycle.
   - No stale beat is ever delivered.
